mr_read_seq: RTL and testbench
==============================

Name: mr_read_seq

Overview:
- Memory-read sequencer directly upstream of the MR-stage select logic.
- Takes the MR-stage latch (valid, read-enable, effective address, operand size) and issues one or two line reads to the D-cache. A second read is needed when the operand straddles a line boundary.
- Merges the bytes, zero-extends them, and returns mem_val together with read_finished. These two signals drive the stage's operand/EIP muxes and stall term.
- Holds the result until the pipeline advances the stage, and handles flushes that arrive while a read is outstanding.

Parameters:
- LINE_BYTES, 16, D-cache line size in bytes (power of 2; the offset field is log2(LINE_BYTES) bits wide).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mr_v  in  1  MR latch holds a valid instruction.
- re  in  1  the instruction needs a memory read.
- addr  in  32  byte address of the operand; stable while mr_v is high and the stage is stalled.
- size  in  2  operand size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 4.
- mr_adv  in  1  the MR latch loads the next instruction this cycle.
- flush  in  1  pipeline flush; the current instruction is killed.
- dc_req  out  1  read request to the D-cache.
- dc_addr  out  32  line-aligned request address (low offset bits = 0).
- dc_ack  in  1  one-cycle pulse: dc_data is valid and the request is consumed.
- dc_data  in  8*LINE_BYTES  line data; byte i occupies bits [8i+7:8i].
- read_finished  out  1  mem_val is valid for the current instruction.
- mem_val  out  32  merged, zero-extended read data.

Behaviour:
- Reset: state IDLE; dc_req=0; dc_addr=0; read_finished=0; mem_val=0. Reset has priority over every other input, including in the middle of a request; a dc_ack arriving after reset is ignored.
- Derived values:
  - nb = 1/2/4 bytes from size.
  - off = addr[3:0] (for LINE_BYTES=16).
  - split = (off + nb > LINE_BYTES), computed with a 5-bit sum.
- IDLE:
  - If mr_v & re & ~flush: go to REQ1 with dc_req=1 and dc_addr = addr with the offset bits cleared.
  - Otherwise stay; read_finished=0.
- REQ1 (dc_req held high, dc_addr held stable until dc_ack):
  - On dc_ack with no split: capture bytes off..off+nb-1 into mem_val[8nb-1:0], upper bits 0, and go to DONE.
  - On dc_ack with split: capture k = LINE_BYTES-off bytes into mem_val[8k-1:0], then go to REQ2 with dc_addr = line address + LINE_BYTES (32-bit wrap: 0xFFFFFFF0 -> 0x00000000).
- REQ2:
  - On dc_ack: bytes 0..nb-k-1 of dc_data go to mem_val[8nb-1:8k]; go to DONE.
- DONE:
  - read_finished=1 and dc_req=0; mem_val is held.
  - On mr_adv or flush: go to IDLE and clear read_finished in the next cycle.
- Flush:
  - In IDLE or DONE: go to IDLE.
  - In REQ1 or REQ2 with dc_ack in the same cycle: go to IDLE; data discarded.
  - In REQ1 or REQ2 without dc_ack: go to DRAIN.
- DRAIN: keep dc_req and dc_addr held; on dc_ack go to IDLE with data discarded; read_finished stays 0. A request is never withdrawn before its ack.
- Latency: a non-split read with dc_ack in the cycle after the request has read_finished high 2 cycles after the IDLE->REQ1 edge. A split read takes +1 cycle per additional ack wait.
- Intervals: at least one IDLE cycle separates consecutive reads.
- mr_v & ~re in IDLE: no request, read_finished=0. The downstream stall term is gated by re, so this is safe.
- mr_adv while in REQ1 or REQ2 is illegal (upstream stalls on ~read_finished) and is flagged by a bench assertion.
- Outputs are registered; no combinational path from dc_ack to read_finished.

Decomposition:
- Shared package (mr_pkg):
  - state encoding: IDLE, REQ1, REQ2, DONE, DRAIN;
  - size codes;
  - LINE_BYTES and its offset width.
- Sub-module byte_extract: combinational. Given a line, a start byte, a count and a destination byte lane, it produces a 32-bit byte-enabled value. It is instantiated once and shared between REQ1 and REQ2, with its inputs muxed by state.
- The FSM and the mem_val byte-enable register live in mr_read_seq.

Test Plan:
- Aligned dword: addr=0x1004, size=2; dc_ack one cycle after the request with line bytes 0..15 = 0x00..0x0F. Expect dc_addr=0x1000, one request, mem_val=0x07060504, and read_finished high until mr_adv.
- Byte read: addr=0x200F, size=0, line byte 15 = 0xAB. Expect mem_val=0x000000AB with no split.
- Split dword: addr=0x300E, size=2; line 0x3000 bytes 14,15 = 0x11,0x22; line 0x3010 bytes 0,1 = 0x33,0x44. Expect requests 0x3000 then 0x3010, and mem_val=0x44332211.
- Wrap split: addr=0xFFFFFFFF, size=1. Expect requests 0xFFFFFFF0 then 0x00000000; mem_val = {line2 byte0, line1 byte15}.
- Flush mid-request: flush in REQ1 with dc_ack delayed 3 cycles. Expect dc_req held until the ack, then IDLE with read_finished never asserted. The next read (addr=0x1004) returns correct data.
- Reset mid-REQ2 (synchronous reset asserted): next cycle dc_req=0, read_finished=0, mem_val=0, state IDLE.

Source files
------------

// File: rtl/mr_pkg.sv
// Shared definitions for the MR-stage memory-read sequencer.
//   - Default D-cache line size, its offset width and the address width.
//   - FSM state encoding (plain constants so legacy tools can read them).
//   - Operand size codes and a helper that turns a size code into a byte count.
package mr_pkg;

    localparam int MR_LINE_BYTES = 16;
    localparam int MR_OFF_W      = $clog2(MR_LINE_BYTES);
    localparam int MR_ADDR_W     = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ1  = 3'd1;
    localparam logic [2:0] ST_REQ2  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    // Code 3 is illegal; it is read as a 4-byte operand.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] nb;
        case (sz)
            SZ_BYTE: nb = 3'd1;
            SZ_HALF: nb = 3'd2;
            default: nb = 3'd4;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/mr_read_seq_byte_extract.sv
// byte_extract: combinational byte picker shared by both read phases.
// Copies count_i bytes of line_i, starting at byte start_i, into the 32-bit
// result beginning at byte lane lane_i. Lanes not written are zero and have
// their byte-enable cleared.
//   line_i   in  one D-cache line (byte i at bits [8i+7:8i])
//   start_i  in  first source byte within the line
//   count_i  in  number of bytes to copy (0..4)
//   lane_i   in  first destination byte lane (0..3)
//   val_o    out byte-placed value, zero outside the enabled lanes
//   be_o     out per-lane byte enable
module byte_extract
    import mr_pkg::*;
#(
    parameter  int LINE_BYTES = MR_LINE_BYTES,
    localparam int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic [8*LINE_BYTES-1:0] line_i,
    input  logic [OFF_W-1:0]        start_i,
    input  logic [2:0]              count_i,
    input  logic [2:0]              lane_i,
    output logic [31:0]             val_o,
    output logic [3:0]              be_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [2:0]       rel;
            logic [OFF_W-1:0] src;

            // Position of this lane relative to the first destination lane.
            assign rel          = 3'(gi) - lane_i;
            assign be_o[gi]     = (3'(gi) >= lane_i) && (rel < count_i);
            assign src          = start_i + OFF_W'(rel);
            assign val_o[8*gi +: 8] = be_o[gi] ? line_i[{src, 3'b000} +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/mr_read_seq.sv
// mr_read_seq: MR-stage memory-read sequencer.
// Issues one D-cache line read, or two when the operand straddles a line
// boundary, merges and zero-extends the bytes, and holds the result with
// read_finished until the stage advances or is flushed. A flush that catches
// an outstanding request keeps the request up until its ack (DRAIN).
//   clk, reset      clock and synchronous active-high reset
//   mr_v, re        MR latch valid / instruction needs a memory read
//   addr, size      operand byte address and size code
//   mr_adv, flush   stage advance / kill current instruction
//   dc_req, dc_addr line read request and line-aligned address
//   dc_ack, dc_data request consumed and its line data
//   read_finished   mem_val valid for the current instruction
//   mem_val         merged, zero-extended read data
module mr_read_seq
    import mr_pkg::*;
#(
    parameter int LINE_BYTES = MR_LINE_BYTES,
    parameter int ADDR_W     = MR_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mr_v,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [1:0]              size,
    input  logic                    mr_adv,
    input  logic                    flush,
    output logic                    dc_req,
    output logic [ADDR_W-1:0]       dc_addr,
    input  logic                    dc_ack,
    input  logic [8*LINE_BYTES-1:0] dc_data,
    output logic                    read_finished,
    output logic [31:0]             mem_val
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [2:0]        state_q, state_d;
    logic              dc_req_q, dc_req_d;
    logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
    logic              rf_q, rf_d;
    logic [31:0]       mem_val_q, mem_val_d;

    logic [2:0]       nb;
    logic [OFF_W-1:0] off;
    logic [OFF_W:0]   off_sum;
    logic             split;
    logic [2:0]       k3;

    logic [OFF_W-1:0] ex_start;
    logic [2:0]       ex_count;
    logic [2:0]       ex_lane;
    logic [31:0]      ex_val;
    logic [3:0]       ex_be;
    logic [31:0]      ex_mask;

    // addr and size are stable while the read is in flight, so the split
    // geometry is recomputed every cycle instead of being stored.
    assign nb      = size_bytes(size);
    assign off     = addr[OFF_W-1:0];
    assign off_sum = {1'b0, off} + (OFF_W+1)'(nb);
    assign split   = off_sum > (OFF_W+1)'(LINE_BYTES);
    // Bytes left in the first line (LINE_BYTES - off). Only used when split,
    // where it is 1..3, so the low three bits of -off are enough.
    assign k3      = 3'(OFF_W'(0) - off);

    // One extractor serves both phases: the tail of the first line into the
    // low lanes, then the head of the second line into the lanes above it.
    always_comb begin
        if (state_q == ST_REQ2) begin
            ex_start = '0;
            ex_count = nb - k3;
            ex_lane  = k3;
        end else begin
            ex_start = off;
            ex_count = split ? k3 : nb;
            ex_lane  = 3'd0;
        end
    end

    byte_extract #(
        .LINE_BYTES (LINE_BYTES)
    ) u_extract (
        .line_i  (dc_data),
        .start_i (ex_start),
        .count_i (ex_count),
        .lane_i  (ex_lane),
        .val_o   (ex_val),
        .be_o    (ex_be)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign ex_mask[8*gi +: 8] = {8{ex_be[gi]}};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        dc_addr_d = dc_addr_q;
        mem_val_d = mem_val_q;
        case (state_q)
            ST_IDLE: begin
                if (mr_v && re && !flush) begin
                    state_d   = ST_REQ1;
                    dc_addr_d = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            ST_REQ1: begin
                if (dc_ack) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Full overwrite: lanes above the captured bytes clear.
                        mem_val_d = ex_val;
                        if (split) begin
                            state_d   = ST_REQ2;
                            dc_addr_d = dc_addr_q + ADDR_W'(LINE_BYTES);
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_REQ2: begin
                if (dc_ack) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        mem_val_d = (mem_val_q & ~ex_mask) | ex_val;
                        state_d   = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (mr_adv || flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The cache still owns the request; wait it out, drop the data.
                if (dc_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dc_req_d = (state_d == ST_REQ1) || (state_d == ST_REQ2) || (state_d == ST_DRAIN);
    assign rf_d     = (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dc_req_q  <= 1'b0;
            dc_addr_q <= '0;
            rf_q      <= 1'b0;
            mem_val_q <= '0;
        end else begin
            state_q   <= state_d;
            dc_req_q  <= dc_req_d;
            dc_addr_q <= dc_addr_d;
            rf_q      <= rf_d;
            mem_val_q <= mem_val_d;
        end
    end

    assign dc_req        = dc_req_q;
    assign dc_addr       = dc_addr_q;
    assign read_finished = rf_q;
    assign mem_val       = mem_val_q;

endmodule

// File: tb/tb_mr_read_seq.sv
`timescale 1ns/1ps
module tb_mr_read_seq;
    import mr_pkg::*;

    localparam int LB = 16;

    logic          clk = 1'b0;
    logic          reset, mr_v, re, mr_adv, flush;
    logic [31:0]   addr;
    logic [1:0]    size;
    logic          dc_req, dc_ack, read_finished;
    logic [31:0]   dc_addr, mem_val;
    logic [8*LB-1:0] dc_data;

    always #5 clk = ~clk;

    mr_read_seq #(.LINE_BYTES(LB), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mr_v          (mr_v),
        .re            (re),
        .addr          (addr),
        .size          (size),
        .mr_adv        (mr_adv),
        .flush         (flush),
        .dc_req        (dc_req),
        .dc_addr       (dc_addr),
        .dc_ack        (dc_ack),
        .dc_data       (dc_data),
        .read_finished (read_finished),
        .mem_val       (mem_val)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: line addresses the cache must see, values read_finished must show.
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_val_q[$];

    int ack_delay = 0;
    int acks_left = 1000;
    bit stray_ack = 1'b0;
    int wait_cnt  = 0;
    logic rf_prev = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        int          delay;
        bit          split;
        logic [31:0] req1;
        logic [31:0] req2;
        logic [31:0] exp_val;
        int          lat;
        bit          kill;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory image of the cache.
    function automatic logic [7:0] line_byte(input logic [31:0] la, input int i);
        logic [7:0] b;
        logic [7:0] base;
        case (la)
            32'h0000_1000: b = 8'(i);
            32'h0000_2000: b = (i == 15) ? 8'hAB : 8'h5A;
            32'h0000_3000: b = (i == 14) ? 8'h11 : (i == 15) ? 8'h22 : 8'hEE;
            32'h0000_3010: b = (i == 0) ? 8'h33 : (i == 1) ? 8'h44 : 8'hDD;
            default: begin
                base = {la[7:4], 4'h0};
                b = (base + 8'(i)) ^ 8'h5C;
            end
        endcase
        return b;
    endfunction

    function automatic logic [8*LB-1:0] make_line(input logic [31:0] la);
        logic [8*LB-1:0] l;
        for (int i = 0; i < LB; i++) l[8*i +: 8] = line_byte(la, i);
        return l;
    endfunction

    // D-cache responder: acks each request after ack_delay waiting cycles.
    initial begin : responder
        dc_ack  = 1'b0;
        dc_data = '0;
        forever begin
            @(negedge clk);
            dc_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
            end else if (stray_ack) begin
                stray_ack = 1'b0;
                dc_ack    = 1'b1;
                dc_data   = make_line(32'h0000_5550);
            end else if (dc_req && acks_left > 0) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    acks_left--;
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dc_req_unexpected: got request 0x%08h, required none", dc_addr);
                    end else begin
                        chk("dc_addr", dc_addr, exp_req_q.pop_front());
                    end
                    dc_ack  = 1'b1;
                    dc_data = make_line(dc_addr);
                end
            end
        end
    end

    // Result monitor: every rising read_finished must match the next expected value.
    initial begin : rf_monitor
        forever begin
            @(negedge clk);
            if (read_finished && !rf_prev) begin
                if (exp_val_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_finished_unexpected: got 1 with mem_val 0x%08h, required 0", mem_val);
                end else begin
                    chk("mem_val", mem_val, exp_val_q.pop_front());
                end
            end
            rf_prev = read_finished;
        end
    end

    // Advancing the stage with a read outstanding is an upstream protocol error.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mr_adv && (dut.state_q == ST_REQ1 || dut.state_q == ST_REQ2)))
                else $error("FAIL mr_adv_illegal: mr_adv asserted while a read is outstanding");
        end
    end

    task automatic do_read(input vec_t v, input int idx);
        int cyc;
        bit got;
        exp_req_q.push_back(v.req1);
        if (v.split) exp_req_q.push_back(v.req2);
        exp_val_q.push_back(v.exp_val);
        ack_delay = v.delay;
        @(negedge clk);
        mr_v = 1'b1; re = 1'b1; addr = v.addr; size = v.size;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (read_finished) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rf_timeout: got no read_finished in 40 cycles, required one (addr 0x%08h)", v.addr);
        end
        chk("latency", cyc, v.lat);
        repeat (2) @(negedge clk);
        chk("rf_hold", {31'd0, read_finished}, 32'd1);
        chk("mem_hold", mem_val, v.exp_val);
        if (v.kill) flush = 1'b1;
        else        mr_adv = 1'b1;
        @(negedge clk);
        mr_adv = 1'b0; flush = 1'b0; mr_v = 1'b0; re = 1'b0;
        chk("rf_after_adv", {31'd0, read_finished}, 32'd0);
        chk("dc_req_idle", {31'd0, dc_req}, 32'd0);
        chk("req_left", exp_req_q.size(), 32'd0);
        $display("txn %0d: addr=0x%08h size=%0d mem_val=0x%08h latency=%0d", idx, v.addr, v.size, mem_val, cyc);
    endtask

    initial begin : main
        vecs[0] = '{32'h0000_1004, 2'd2, 1, 1'b0, 32'h0000_1000, 32'h0, 32'h0706_0504, 3, 1'b0};
        vecs[1] = '{32'h0000_200F, 2'd0, 0, 1'b0, 32'h0000_2000, 32'h0, 32'h0000_00AB, 2, 1'b0};
        vecs[2] = '{32'h0000_300E, 2'd2, 1, 1'b1, 32'h0000_3000, 32'h0000_3010, 32'h4433_2211, 5, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 2'd1, 0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_5CA3, 3, 1'b0};
        vecs[4] = '{32'h0000_4122, 2'd1, 2, 1'b0, 32'h0000_4120, 32'h0, 32'h0000_7F7E, 4, 1'b0};
        vecs[5] = '{32'h0000_405D, 2'd2, 0, 1'b1, 32'h0000_4050, 32'h0000_4060, 32'h3C03_0201, 3, 1'b0};
        vecs[6] = '{32'h0000_407C, 2'd2, 1, 1'b0, 32'h0000_4070, 32'h0, 32'h2322_2120, 3, 1'b0};
        vecs[7] = '{32'h0000_408F, 2'd3, 2, 1'b1, 32'h0000_4080, 32'h0000_4090, 32'hCECD_CCD3, 7, 1'b0};
        vecs[8] = '{32'h0000_40A7, 2'd0, 0, 1'b0, 32'h0000_40A0, 32'h0, 32'h0000_00FB, 2, 1'b0};
        vecs[9] = '{32'h0000_3007, 2'd1, 0, 1'b0, 32'h0000_3000, 32'h0, 32'h0000_EEEE, 2, 1'b1};

        reset = 1'b1; mr_v = 1'b0; re = 1'b0; addr = '0; size = '0;
        mr_adv = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_dc_req", {31'd0, dc_req}, 32'd0);
        chk("reset_dc_addr", dc_addr, 32'd0);
        chk("reset_rf", {31'd0, read_finished}, 32'd0);
        chk("reset_mem_val", mem_val, 32'd0);

        // Valid instruction without a memory read: no request.
        mr_v = 1'b1; re = 1'b0; addr = 32'h0000_1004; size = 2'd2;
        repeat (3) begin
            @(negedge clk);
            chk("no_re_dc_req", {31'd0, dc_req}, 32'd0);
            chk("no_re_rf", {31'd0, read_finished}, 32'd0);
        end
        mr_v = 1'b0;

        for (int i = 0; i < 10; i++) do_read(vecs[i], i);

        // Flush while REQ1 waits for a late ack: request held, then dropped.
        exp_req_q.push_back(32'h0000_1000);
        ack_delay = 3;
        @(negedge clk);
        mr_v = 1'b1; re = 1'b1; addr = 32'h0000_1004; size = 2'd2;
        @(negedge clk);
        flush = 1'b1; mr_v = 1'b0; re = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_dc_addr", dc_addr, 32'h0000_1000);
        repeat (3) begin
            chk("drain_dc_req", {31'd0, dc_req}, 32'd1);
            @(negedge clk);
        end
        chk("drain_done_dc_req", {31'd0, dc_req}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("drain_rf", {31'd0, read_finished}, 32'd0);
        end
        chk("drain_req_left", exp_req_q.size(), 32'd0);
        $display("txn flush_drain: addr=0x00001004 request held until ack, data dropped");
        do_read(vecs[0], 10);

        // Flush in the same cycle as the ack: straight back to IDLE.
        exp_req_q.push_back(32'h0000_2000);
        ack_delay = 0;
        @(negedge clk);
        mr_v = 1'b1; re = 1'b1; addr = 32'h0000_200F; size = 2'd0;
        @(negedge clk);
        flush = 1'b1; mr_v = 1'b0; re = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ack_dc_req", {31'd0, dc_req}, 32'd0);
        @(negedge clk);
        chk("flush_ack_rf", {31'd0, read_finished}, 32'd0);
        $display("txn flush_with_ack: addr=0x0000200F dropped");

        // Flush held in IDLE blocks a new request.
        mr_v = 1'b1; re = 1'b1; flush = 1'b1; addr = 32'h0000_1004; size = 2'd2;
        repeat (2) begin
            @(negedge clk);
            chk("idle_flush_dc_req", {31'd0, dc_req}, 32'd0);
        end
        mr_v = 1'b0; re = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset while REQ2 is outstanding, then a stray ack must be ignored.
        exp_req_q.push_back(32'h0000_3000);
        ack_delay = 0;
        acks_left = 1;
        @(negedge clk);
        mr_v = 1'b1; re = 1'b1; addr = 32'h0000_300E; size = 2'd2;
        @(negedge clk);
        @(negedge clk);
        chk("req2_dc_req", {31'd0, dc_req}, 32'd1);
        chk("req2_dc_addr", dc_addr, 32'h0000_3010);
        reset = 1'b1; mr_v = 1'b0; re = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req2_dc_req", {31'd0, dc_req}, 32'd0);
        chk("rst_req2_dc_addr", dc_addr, 32'd0);
        chk("rst_req2_rf", {31'd0, read_finished}, 32'd0);
        chk("rst_req2_mem_val", mem_val, 32'd0);
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_dc_req", {31'd0, dc_req}, 32'd0);
            chk("stray_ack_mem_val", mem_val, 32'd0);
        end
        acks_left = 1000;
        chk("rst_req_left", exp_req_q.size(), 32'd0);
        $display("txn reset_in_req2: addr=0x0000300E aborted by reset");
        do_read(vecs[2], 11);

        repeat (2) @(negedge clk);
        chk("val_left", exp_val_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
